// File: rtl/ddr3_init_seq_if.sv
// DDR3 command/control pin bundle driven by the init sequencer.
// The master modport drives the pins; the slave modport observes them.
interface ddr3_init_seq_if #(
    parameter int ADDR_BITS = 14,
    parameter int BA_BITS   = 3
);
    logic                 ddr_rst_n;
    logic                 cke;
    logic                 cs_n;
    logic                 ras_n;
    logic                 cas_n;
    logic                 we_n;
    logic [BA_BITS-1:0]   ba;
    logic [ADDR_BITS-1:0] addr;
    logic                 odt;
    logic                 init_done;

    modport master (
        output ddr_rst_n, cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt, init_done
    );
    modport slave (
        input  ddr_rst_n, cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt, init_done
    );
endinterface

// File: rtl/ddr3_init_seq.sv
// DDR3 power-up sequencer: RESET#/CKE ramp, MR2/MR3/MR1/MR0 loads, ZQCL, then init_done.
// Each wait state counts down once; the command that ends the wait is emitted on the expiring edge.
module ddr3_init_seq #(
    parameter int ADDR_BITS = 14,
    parameter int BA_BITS   = 3,
    parameter int T_RESET   = 100000,
    parameter int T_CKE     = 250000,
    parameter int T_XPR     = 64,
    parameter int T_MRD     = 4,
    parameter int T_MOD     = 12,
    parameter int T_ZQINIT  = 512,
    parameter logic [ADDR_BITS-1:0] MR0_VAL = '0,
    parameter logic [ADDR_BITS-1:0] MR1_VAL = '0,
    parameter logic [ADDR_BITS-1:0] MR2_VAL = '0,
    parameter logic [ADDR_BITS-1:0] MR3_VAL = '0
) (
    input  logic             ck,
    input  logic             rst,
    ddr3_init_seq_if.master  bus
);
    localparam int CW = 20;
    localparam logic [ADDR_BITS-1:0] ZQ_ADDR = ADDR_BITS'(11'h400);

    typedef enum logic [3:0] {
        RST_WAIT, CKE_WAIT, XPR_WAIT, MRS2, MRS3, MRS1, MOD_WAIT, ZQ_WAIT, DONE
    } state_e;

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic                 ddr_rst_n_q, cke_q, cs_n_q, ras_n_q, cas_n_q, we_n_q, done_q;
    logic [BA_BITS-1:0]   ba_q;
    logic [ADDR_BITS-1:0] addr_q;

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q     <= RST_WAIT;
            // Loaded with the full count: the reset edge itself is the entry edge of RST_WAIT.
            cnt_q       <= CW'(T_RESET);
            ddr_rst_n_q <= 1'b0;
            cke_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            ras_n_q     <= 1'b1;
            cas_n_q     <= 1'b1;
            we_n_q      <= 1'b1;
            ba_q        <= '0;
            addr_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            // Idle bus: deselect before CKE is up, NOP afterwards.
            cs_n_q  <= ~cke_q;
            ras_n_q <= 1'b1;
            cas_n_q <= 1'b1;
            we_n_q  <= 1'b1;
            ba_q    <= '0;
            addr_q  <= '0;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end else begin
                case (state_q)
                    RST_WAIT: begin
                        ddr_rst_n_q <= 1'b1;
                        cnt_q       <= CW'(T_CKE - 1);
                        state_q     <= CKE_WAIT;
                    end
                    CKE_WAIT: begin
                        cke_q   <= 1'b1;
                        cs_n_q  <= 1'b0;
                        cnt_q   <= CW'(T_XPR - 1);
                        state_q <= XPR_WAIT;
                    end
                    XPR_WAIT: begin
                        {cs_n_q, ras_n_q, cas_n_q, we_n_q} <= 4'b0000;
                        ba_q    <= BA_BITS'(2);
                        addr_q  <= MR2_VAL;
                        cnt_q   <= CW'(T_MRD - 1);
                        state_q <= MRS2;
                    end
                    MRS2: begin
                        {cs_n_q, ras_n_q, cas_n_q, we_n_q} <= 4'b0000;
                        ba_q    <= BA_BITS'(3);
                        addr_q  <= MR3_VAL;
                        cnt_q   <= CW'(T_MRD - 1);
                        state_q <= MRS3;
                    end
                    MRS3: begin
                        {cs_n_q, ras_n_q, cas_n_q, we_n_q} <= 4'b0000;
                        ba_q    <= BA_BITS'(1);
                        addr_q  <= MR1_VAL;
                        cnt_q   <= CW'(T_MRD - 1);
                        state_q <= MRS1;
                    end
                    MRS1: begin
                        {cs_n_q, ras_n_q, cas_n_q, we_n_q} <= 4'b0000;
                        ba_q    <= BA_BITS'(0);
                        addr_q  <= MR0_VAL;
                        cnt_q   <= CW'(T_MOD - 1);
                        state_q <= MOD_WAIT;
                    end
                    MOD_WAIT: begin
                        {cs_n_q, ras_n_q, cas_n_q, we_n_q} <= 4'b0110;
                        addr_q  <= ZQ_ADDR;
                        cnt_q   <= CW'(T_ZQINIT - 1);
                        state_q <= ZQ_WAIT;
                    end
                    ZQ_WAIT: begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                    DONE:    state_q <= DONE;
                    default: state_q <= RST_WAIT;
                endcase
            end
        end
    end

    assign bus.ddr_rst_n = ddr_rst_n_q;
    assign bus.cke       = cke_q;
    assign bus.cs_n      = cs_n_q;
    assign bus.ras_n     = ras_n_q;
    assign bus.cas_n     = cas_n_q;
    assign bus.we_n      = we_n_q;
    assign bus.ba        = ba_q;
    assign bus.addr      = addr_q;
    assign bus.odt       = 1'b0;
    assign bus.init_done = done_q;
endmodule

// File: doc/ddr3_init_seq.md
Name: ddr3_init_seq

Overview:
Power-up initialization sequencer sitting directly upstream of ddr3_controller on the DDR3 command pins. It drives the JEDEC reset/CKE ramp and issues the MRS (MR2, MR3, MR1, MR0) and ZQCL command sequence. It then asserts init_done, which hands command-bus ownership to the controller. Timing is parameterized in ck cycles so simulation can use scaled values.

Parameters:
ADDR_BITS, 14, DDR3 address bus width
BA_BITS, 3, bank address width
T_RESET, 100000, cycles ddr_rst_n held low after rst release (>=1)
T_CKE, 250000, cycles from ddr_rst_n rise to cke rise (>=1)
T_XPR, 64, cycles from cke rise to first MRS (>=1)
T_MRD, 4, MRS-to-MRS command spacing in cycles (>=1)
T_MOD, 12, MR0-to-ZQCL spacing in cycles (>=1)
T_ZQINIT, 512, ZQCL to init_done in cycles (>=1)
MR0_VAL, MR1_VAL, MR2_VAL, MR3_VAL, 0, ADDR_BITS-wide mode register contents

Ports:
ck  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
ddr_rst_n  output  1  DRAM RESET# pin
cke  output  1  clock enable
cs_n  output  1  chip select
ras_n  output  1  row strobe
cas_n  output  1  column strobe
we_n  output  1  write enable
ba  output  BA_BITS  bank / mode-register select
addr  output  ADDR_BITS  address / mode-register data
odt  output  1  on-die termination; held 0 throughout init
init_done  output  1  sequence complete; sticky until rst

Behaviour:
- All outputs are registered. Cycle 0 is the first rising edge at which rst is sampled low. "At cycle n" means the value is visible after edge n.
- Reset values (while rst=1 and at cycle 0): ddr_rst_n=0, cke=0, cs_n=1, ras_n=cas_n=we_n=1, ba=0, addr=0, odt=0, init_done=0.
- FSM states: RST_WAIT -> CKE_WAIT -> XPR_WAIT -> MRS2 -> MRS3 -> MRS1 -> MRS0 -> MOD_WAIT -> ZQCL -> ZQ_WAIT -> DONE. A single down-counter of at least 20 bits is reloaded on each state entry.
- RST_WAIT: ddr_rst_n=1 at cycle T_RESET.
- CKE_WAIT: cke=1 at cycle T_RESET+T_CKE (=C). cs_n=1 (deselect) until cke rises. From C onward, idle cycles drive NOP: cs_n=0, ras_n=cas_n=we_n=1, ba=0, addr=0.
- XPR_WAIT: MRS to MR2 issued at cycle C+T_XPR.
- MRS command: single cycle with cs_n=ras_n=cas_n=we_n=0, ba=MR index (2,3,1,0), addr=MRx_VAL.
- MRS spacing: MR3 at +T_MRD after MR2, MR1 at +T_MRD after MR3, MR0 at +T_MRD after MR1. NOP in between.
- ZQCL: single cycle issued T_MOD after MR0, with cs_n=0, ras_n=1, cas_n=1, we_n=0, addr[10]=1, other addr bits 0, ba=0.
- init_done=1 at T_ZQINIT cycles after ZQCL.
- DONE: init_done stays 1 and cke stays 1. Command pins hold NOP until rst. The block never re-enters the sequence without rst.
- Every command is exactly one cycle wide. No two commands are ever issued on adjacent cycles unless the spacing parameter is 1.
- Reset mid-sequence: rst=1 in any state returns all outputs to reset values at the next edge and restarts from RST_WAIT. Partially issued MRS sequences are not resumed.
- rst=1 in DONE clears init_done at the next edge.
- Counter arithmetic: reload value = parameter-1. State transition occurs on the counter reaching 0. Parameters of 1 must yield back-to-back transitions.

Test Plan:
1. Small params (T_RESET=4, T_CKE=5, T_XPR=6, T_MRD=4, T_MOD=12, T_ZQINIT=16), MR0..3=14'h0520,14'h0044,14'h0008,14'h0000 -> ddr_rst_n rises cycle 4, cke cycle 9, MRS ba=2 cycle 15, ba=3 cycle 19, ba=1 cycle 23, ba=0 addr=14'h0520 cycle 27, ZQCL addr=14'h0400 cycle 39, init_done cycle 55.
2. Same params, monitor bus every cycle -> cs_n=1 for cycles 0-8. Exactly 5 non-NOP commands total, each 1 cycle wide. odt=0 always.
3. Assert rst for 1 cycle at cycle 21 (between MR3 and MR1) -> next edge all outputs at reset values. Full sequence repeats with identical relative timing (MR2 at 15 cycles after release).
4. All timing params =1 -> ddr_rst_n cycle 1, cke cycle 2, MR2..MR0 cycles 3,4,5,6, ZQCL cycle 7, init_done cycle 8.
5. Hold 200 cycles after init_done -> init_done, cke, ddr_rst_n stay 1. Bus stays NOP. Then rst=1 -> init_done=0 at the next edge.
